// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_pkg
// Brief    : Shared state encoding and protocol characters for uart_loader.
// Revision : 1.0
// ============================================================================
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        CLEAR = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_DOWNLOAD = 8'h64;  // 'd'
    localparam logic [7:0] CMD_CLEAR    = 8'h63;  // 'c'
    localparam logic [7:0] RSP_START    = 8'h73;  // 's'
    localparam logic [7:0] RSP_READY    = 8'h72;  // 'r'
    localparam logic [7:0] RSP_ERROR    = 8'h65;  // 'e'

endpackage
`default_nettype wire

// File: rtl/uart_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_if
// Brief    : Loader-to-memory write bus (ownership flag, strobe, address, data).
// Revision : 1.0
// ============================================================================
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  load_active;
    logic                  load_wr;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;

    modport master (output load_active, output load_wr, output load_addr, output load_data);
    modport slave  (input  load_active, input  load_wr, input  load_addr, input  load_data);
endinterface
`default_nettype wire

// File: rtl/uart_loader_resp.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_resp
// Brief    : Two-byte response queue, echo holding register and TX source mux.
// Revision : 1.0
// ============================================================================
module uart_loader_resp (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_q_load,
    input  wire logic [1:0] i_q_cnt,
    input  wire logic [7:0] i_q_b0,
    input  wire logic [7:0] i_q_b1,
    input  wire logic       i_echo,
    input  wire logic [7:0] i_echo_data,
    input  wire logic       i_fifo_valid,
    input  wire logic [7:0] i_fifo_data,
    input  wire logic       i_tx_busy,
    output logic            o_tx_start,
    output logic [7:0]      o_tx_data,
    output logic            o_fifo_pop,
    output logic            o_idle
);
    logic [7:0] r_q0, r_q1, r_echo;
    logic [1:0] r_qcnt;
    logic       r_echo_v;
    logic       w_sel_q, w_sel_e, w_sel_d, w_sel_f;

    // queued responses first, then a held echo, then a fresh echo, then console
    always_comb begin
        w_sel_q    = (r_qcnt != 2'd0);
        w_sel_e    = !w_sel_q && r_echo_v;
        w_sel_d    = !w_sel_q && !r_echo_v && i_echo;
        w_sel_f    = !w_sel_q && !r_echo_v && !i_echo && i_fifo_valid;
        o_tx_start = !i_tx_busy && (w_sel_q || w_sel_e || w_sel_d || w_sel_f);
        o_fifo_pop = !i_tx_busy && w_sel_f;
        o_tx_data  = i_fifo_data;
        if (w_sel_q)      o_tx_data = r_q0;
        else if (w_sel_e) o_tx_data = r_echo;
        else if (w_sel_d) o_tx_data = i_echo_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q0     <= '0;
            r_q1     <= '0;
            r_qcnt   <= 2'd0;
            r_echo   <= '0;
            r_echo_v <= 1'b0;
        end else begin
            if (i_q_load) begin
                r_q0   <= i_q_b0;
                r_q1   <= i_q_b1;
                r_qcnt <= i_q_cnt;
            end else if (o_tx_start && w_sel_q) begin
                r_q0   <= r_q1;
                r_qcnt <= r_qcnt - 2'd1;
            end
            if (i_echo && !(o_tx_start && w_sel_d)) begin
                r_echo   <= i_echo_data;
                r_echo_v <= 1'b1;
            end else if (o_tx_start && w_sel_e) begin
                r_echo_v <= 1'b0;
            end
        end
    end

    assign o_idle = (r_qcnt == 2'd0) && !r_echo_v;
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver; one-cycle o_done pulse at mid stop bit.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLK_SPEED = 100_000_000,
    parameter int BAUDRATE  = 115200
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_rxd,
    output logic            o_done,
    output logic [7:0]      o_data
);
    localparam int c_DIV = CLK_SPEED / BAUDRATE;
    localparam int c_CW  = $clog2(c_DIV);

    logic            r_s1, r_s2, r_active, r_done;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_bit;
    logic [7:0]      r_shift, r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= 4'd0;
            r_shift  <= '0;
            r_data   <= '0;
        end else begin
            r_s1   <= i_rxd;
            r_s2   <= r_s1;
            r_done <= 1'b0;
            if (!r_active) begin
                if (!r_s2) begin
                    r_active <= 1'b1;
                    r_cnt    <= c_CW'(c_DIV / 2 - 1);
                    r_bit    <= 4'd0;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CW'(1);
            end else begin
                r_cnt <= c_CW'(c_DIV - 1);
                // bit 0 re-checks the start bit to reject glitches
                if (r_bit == 4'd0) begin
                    if (r_s2) r_active <= 1'b0;
                    else      r_bit    <= 4'd1;
                end else if (r_bit <= 4'd8) begin
                    r_shift <= {r_s2, r_shift[7:1]};
                    r_bit   <= r_bit + 4'd1;
                end else begin
                    r_active <= 1'b0;
                    r_done   <= r_s2;
                    r_data   <= r_shift;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_data = r_data;
endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter; accepts a byte on i_start while not busy.
// Revision : 1.0
// ============================================================================
module uart_tx #(
    parameter int CLK_SPEED = 100_000_000,
    parameter int BAUDRATE  = 115200
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_start,
    input  wire logic [7:0] i_data,
    output logic            o_busy,
    output logic            o_txd
);
    localparam int c_DIV = CLK_SPEED / BAUDRATE;
    localparam int c_CW  = $clog2(c_DIV);

    logic [9:0]      r_shift;
    logic [3:0]      r_bits;
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '1;
            r_bits  <= 4'd0;
            r_cnt   <= '0;
        end else if (r_bits == 4'd0) begin
            if (i_start) begin
                r_shift <= {1'b1, i_data, 1'b0};
                r_bits  <= 4'd10;
                r_cnt   <= c_CW'(c_DIV - 1);
            end
        end else if (r_cnt == '0) begin
            r_shift <= {1'b1, r_shift[9:1]};
            r_bits  <= r_bits - 4'd1;
            r_cnt   <= c_CW'(c_DIV - 1);
        end else begin
            r_cnt <= r_cnt - c_CW'(1);
        end
    end

    assign o_busy = (r_bits != 4'd0);
    assign o_txd  = r_shift[0];
endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader
// Brief    : UART console bridge with download/clear memory-loader protocol.
// Revision : 1.0
// ============================================================================
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_SPEED      = 100_000_000,
    parameter int BAUDRATE       = 115200,
    parameter int WORD_BYTES     = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int ADDR_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = CLK_SPEED * 5,
    parameter int TX_FIFO_DEPTH  = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [7:0] tx_data,
    input  wire logic       tx_req,
    output logic            tx_full,
    output logic            txd,
    input  wire logic       rxd,
    uart_loader_if.master   mem
);
    localparam int c_AB_W = ADDR_BYTES * 8;
    localparam int c_W    = WORD_BYTES * 8;
    localparam int c_FW   = $clog2(TX_FIFO_DEPTH);
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO = c_TO_W'(TIMEOUT_CYCLES);

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_load_addr;
    logic [c_AB_W-1:0]     r_abuf, w_abuf_next;
    logic [c_W-1:0]        r_word, w_word_next, r_load_data;
    logic [3:0]            r_cnt;
    logic [7:0]            r_csum;
    logic [c_TO_W-1:0]     r_timeout;
    logic                  r_load_wr;

    logic       w_rx_done, w_tx_busy, w_tx_start, w_expire, w_echo;
    logic       w_q_load, w_fifo_pop, w_resp_idle, w_push, w_empty;
    logic [1:0] w_q_cnt;
    logic [7:0] w_rx_data, w_tx_data, w_q_b0, w_q_b1;
    logic       w_unused;

    logic [7:0]  r_fifo [TX_FIFO_DEPTH];
    logic [c_FW:0] r_wp, r_rp;

    uart_rx #(.CLK_SPEED(CLK_SPEED), .BAUDRATE(BAUDRATE)) u_rx (
        .clk(clk), .rst(reset), .i_rxd(rxd), .o_done(w_rx_done), .o_data(w_rx_data)
    );

    uart_tx #(.CLK_SPEED(CLK_SPEED), .BAUDRATE(BAUDRATE)) u_tx (
        .clk(clk), .rst(reset), .i_start(w_tx_start), .i_data(w_tx_data),
        .o_busy(w_tx_busy), .o_txd(txd)
    );

    uart_loader_resp u_resp (
        .clk(clk), .rst(reset),
        .i_q_load(w_q_load), .i_q_cnt(w_q_cnt), .i_q_b0(w_q_b0), .i_q_b1(w_q_b1),
        .i_echo(w_echo), .i_echo_data(w_rx_data),
        .i_fifo_valid(!w_empty && !mem.load_active), .i_fifo_data(r_fifo[r_rp[c_FW-1:0]]),
        .i_tx_busy(w_tx_busy), .o_tx_start(w_tx_start), .o_tx_data(w_tx_data),
        .o_fifo_pop(w_fifo_pop), .o_idle(w_resp_idle)
    );

    // console FIFO: a pop in the same cycle frees room for a push while full
    assign w_empty = (r_wp == r_rp);
    assign tx_full = (r_wp[c_FW] != r_rp[c_FW]) && (r_wp[c_FW-1:0] == r_rp[c_FW-1:0]);
    assign w_push  = tx_req && (!tx_full || w_fifo_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push)     r_wp <= r_wp + (c_FW+1)'(1);
            if (w_fifo_pop) r_rp <= r_rp + (c_FW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp[c_FW-1:0]] <= tx_data;
    end

    assign w_abuf_next = c_AB_W'({w_rx_data, r_abuf} >> 8);
    assign w_word_next = c_W'({w_rx_data, r_word} >> 8);
    assign w_expire    = (r_timeout == c_TO_W'(1)) && !w_rx_done;
    assign w_unused    = ^w_abuf_next;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_q_load     = 1'b0;
        w_q_cnt      = 2'd0;
        w_q_b0       = 8'h00;
        w_q_b1       = 8'h00;
        w_echo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rx_done && w_rx_data == CMD_DOWNLOAD) w_state_next = ADDR;
                else if (w_rx_done && w_rx_data == CMD_CLEAR) w_state_next = CLEAR;
            end
            ADDR: begin
                if (w_rx_done && r_cnt == 4'(ADDR_BYTES - 1)) begin
                    w_state_next = DATA;
                    w_q_load = 1'b1;  w_q_cnt = 2'd1;  w_q_b0 = RSP_START;
                end else if (w_expire) begin
                    w_state_next = RESP;
                    w_q_load = 1'b1;  w_q_cnt = 2'd1;  w_q_b0 = RSP_ERROR;
                end
            end
            DATA: begin
                if (w_rx_done) begin
                    w_echo = 1'b1;
                end else if (w_expire) begin
                    w_state_next = RESP;
                    w_q_load = 1'b1;  w_q_cnt = 2'd2;  w_q_b0 = r_csum;  w_q_b1 = RSP_READY;
                end
            end
            CLEAR: begin
                if (r_addr == {ADDR_WIDTH{1'b1}}) begin
                    w_state_next = RESP;
                    w_q_load = 1'b1;  w_q_cnt = 2'd1;  w_q_b0 = RSP_READY;
                end
            end
            RESP: begin
                if (w_resp_idle) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_abuf      <= '0;
            r_word      <= '0;
            r_cnt       <= 4'd0;
            r_csum      <= 8'h00;
            r_timeout   <= '0;
            r_load_wr   <= 1'b0;
            r_load_addr <= '0;
            r_load_data <= '0;
        end else begin
            r_load_wr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt     <= 4'd0;
                    r_csum    <= 8'h00;
                    r_word    <= '0;
                    r_timeout <= (w_rx_done && w_rx_data == CMD_DOWNLOAD) ? c_TO : '0;
                    if (w_rx_done && w_rx_data == CMD_CLEAR) r_addr <= '0;
                end
                ADDR: begin
                    r_timeout <= w_rx_done ? c_TO : r_timeout - c_TO_W'(1);
                    if (w_rx_done) begin
                        r_abuf <= w_abuf_next;
                        if (r_cnt == 4'(ADDR_BYTES - 1)) begin
                            r_addr <= w_abuf_next[ADDR_WIDTH-1:0];
                            r_cnt  <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    r_timeout <= w_rx_done ? c_TO : r_timeout - c_TO_W'(1);
                    if (w_rx_done) begin
                        r_csum <= r_csum + w_rx_data;
                        r_word <= w_word_next;
                        if (r_cnt == 4'(WORD_BYTES - 1)) begin
                            r_load_wr   <= 1'b1;
                            r_load_addr <= r_addr;
                            r_load_data <= w_word_next;
                            r_addr      <= r_addr + ADDR_WIDTH'(1);
                            r_cnt       <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                CLEAR: begin
                    r_load_wr   <= 1'b1;
                    r_load_addr <= r_addr;
                    r_load_data <= '0;
                    r_addr      <= r_addr + ADDR_WIDTH'(1);
                end
                default: r_timeout <= '0;
            endcase
        end
    end

    assign mem.load_active = (r_state != IDLE);
    assign mem.load_wr     = r_load_wr;
    assign mem.load_addr   = r_load_addr;
    assign mem.load_data   = r_load_data;
endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loader
// Brief    : Self-checking bench: console path, download/clear sessions, errors.
// Revision : 1.0
// ============================================================================
module tb_uart_loader;
    localparam int BIT = 16;
    localparam int AW  = 8;
    localparam int WB  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_req = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] tx_data = 8'h00;
    wire        tx_full;
    wire        txd;

    uart_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(WB*8)) mem_if ();

    uart_loader #(
        .CLK_SPEED(1_600_000), .BAUDRATE(100_000), .WORD_BYTES(WB), .ADDR_WIDTH(AW),
        .ADDR_BYTES(2), .TIMEOUT_CYCLES(2000), .TX_FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_req(tx_req), .tx_full(tx_full),
        .txd(txd), .rxd(rxd), .mem(mem_if)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; int cyc; } wr_t;
    typedef struct { logic [7:0] base; logic [7:0] first; int n; logic [7:0] exp_csum; int exp_wr; logic [31:0] exp_d0; } vec_t;

    int         n_vec = 0, n_err = 0, cyc = 0;
    logic [7:0] tx_q[$], stim_q[$], exp_q[$];
    wr_t        wr_q[$];
    bit         full_seen = 0, active_seen = 0;
    vec_t       tbl[3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_if.load_wr === 1'b1) wr_q.push_back('{mem_if.load_addr, mem_if.load_data, cyc});
        if (tx_full === 1'b1) full_seen = 1;
        if (mem_if.load_active === 1'b1) active_seen = 1;
    end

    // TXD decoder: sample each bit at its centre
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0 && !reset) begin
                repeat (BIT/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                tx_q.push_back(b);
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (BIT*3) @(negedge clk);
    endtask

    task automatic push_con(input logic [7:0] b);
        tx_data = b;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req  = 1'b0;
    endtask

    task automatic wait_idle(input int tail);
        int t;
        t = 0;
        while (mem_if.load_active === 1'b1 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check("session_end_bound", {63'd0, mem_if.load_active}, 64'd0);
        repeat (tail) @(negedge clk);
    endtask

    task automatic compare_tx(input string name);
        check({name, "_tx_count"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < tx_q.size()) check({name, "_tx_byte"}, tx_q[i], exp_q[i]);
    endtask

    // reference model: 's', one echo per byte, sum mod 256, 'r'; whole words only
    task automatic do_download(input string name, input logic [7:0] base);
        logic [7:0]  sum;
        logic [31:0] d;
        int          nw;
        tx_q.delete(); wr_q.delete(); exp_q.delete();
        send_rx(8'h64); send_rx(base); send_rx(8'h00);
        foreach (stim_q[i]) send_rx(stim_q[i]);
        wait_idle(400);
        sum = 0;
        exp_q.push_back(8'h73);
        foreach (stim_q[i]) begin
            exp_q.push_back(stim_q[i]);
            sum = sum + stim_q[i];
        end
        exp_q.push_back(sum);
        exp_q.push_back(8'h72);
        compare_tx(name);
        nw = stim_q.size() / WB;
        check({name, "_wr_count"}, wr_q.size(), nw);
        for (int w = 0; w < nw && w < wr_q.size(); w++) begin
            d = 0;
            for (int k = 0; k < WB; k++) d = d | (32'(stim_q[w*WB + k]) << (8*k));
            check({name, "_wr_addr"}, wr_q[w].a, (base + w) % 256);
            check({name, "_wr_data"}, wr_q[w].d, d);
        end
    endtask

    initial begin
        int bad;
        tbl[0] = '{8'h10, 8'h01, 8, 8'h24, 2, 32'h04030201};
        tbl[1] = '{8'hFF, 8'h11, 8, 8'hA4, 2, 32'h14131211};
        tbl[2] = '{8'h00, 8'hAA, 6, 8'h0B, 1, 32'hADACABAA};

        repeat (4) @(negedge clk);
        check("reset_txd", {63'd0, txd}, 64'd1);
        check("reset_full", {63'd0, tx_full}, 64'd0);
        check("reset_active", {63'd0, mem_if.load_active}, 64'd0);
        check("reset_wr", {63'd0, mem_if.load_wr}, 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // console only
        tx_q.delete(); full_seen = 0; active_seen = 0;
        push_con(8'h48); push_con(8'h69);
        repeat (400) @(negedge clk);
        exp_q = '{8'h48, 8'h69};
        compare_tx("console");
        check("console_full_seen", {63'd0, full_seen}, 64'd0);
        check("console_active_seen", {63'd0, active_seen}, 64'd0);

        // burst: one byte goes straight to the transmitter, 16 more fit, rest dropped
        tx_q.delete(); exp_q.delete(); full_seen = 0;
        for (int i = 0; i < 20; i++) begin
            stim_q[i] = 8'($urandom);
            if (i < 17) exp_q.push_back(stim_q[i]);
            push_con(stim_q[i]);
        end
        repeat (17*10*BIT + 400) @(negedge clk);
        compare_tx("burst");
        check("burst_full_seen", {63'd0, full_seen}, 64'd1);

        // table-driven download sessions
        for (int v = 0; v < 3; v++) begin
            stim_q.delete();
            for (int i = 0; i < tbl[v].n; i++) stim_q.push_back(tbl[v].first + 8'(i));
            do_download("table", tbl[v].base);
            if (tx_q.size() > tbl[v].n + 1) check("table_csum", tx_q[tbl[v].n + 1], tbl[v].exp_csum);
            check("table_nwr", wr_q.size(), tbl[v].exp_wr);
            if (wr_q.size() > 0) check("table_d0", wr_q[0].d, tbl[v].exp_d0);
        end

        // randomized download sessions
        for (int s = 0; s < 5; s++) begin
            stim_q.delete();
            for (int i = 0; i < $urandom_range(1, 11); i++) stim_q.push_back(8'($urandom));
            do_download("random", 8'($urandom_range(0, 255)));
        end

        // clear with console traffic queued meanwhile
        tx_q.delete(); wr_q.delete();
        send_rx(8'h63);
        check("clear_active", {63'd0, mem_if.load_active}, 64'd1);
        push_con(8'h6F); push_con(8'h6B);
        wait_idle(600);
        exp_q = '{8'h72, 8'h6F, 8'h6B};
        compare_tx("clear");
        check("clear_wr_count", wr_q.size(), 256);
        bad = 0;
        foreach (wr_q[i])
            if (wr_q[i].a !== 8'(i) || wr_q[i].d !== 32'd0 || wr_q[i].cyc != wr_q[0].cyc + i) bad++;
        check("clear_wr_sequence", bad, 0);

        // address phase timeout
        tx_q.delete(); wr_q.delete();
        send_rx(8'h64); send_rx(8'h20);
        wait_idle(400);
        exp_q = '{8'h65};
        compare_tx("addr_timeout");
        check("addr_timeout_wr", wr_q.size(), 0);

        // reset in the middle of a data phase
        send_rx(8'h64); send_rx(8'h00); send_rx(8'h00);
        send_rx(8'h01); send_rx(8'h02); send_rx(8'h03);
        repeat (200) @(negedge clk);
        tx_q.delete(); wr_q.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_active", {63'd0, mem_if.load_active}, 64'd0);
        check("mid_reset_addr", mem_if.load_addr, 0);
        check("mid_reset_data", mem_if.load_data, 0);
        check("mid_reset_txd", {63'd0, txd}, 64'd1);
        send_rx(8'h04);
        repeat (2500) @(negedge clk);
        check("mid_reset_tx", tx_q.size(), 0);
        check("mid_reset_wr", wr_q.size(), 0);
        check("mid_reset_idle", {63'd0, mem_if.load_active}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
